// File: rtl/dataplane_csr_pkg.sv
// dataplane_csr shared definitions: register map, CTRL layout
// and the control-register bundle.
package dataplane_csr_pkg;

    localparam logic [7:0] REG_ID         = 8'h00;
    localparam logic [7:0] REG_SCRATCH    = 8'h04;
    localparam logic [7:0] REG_CTRL       = 8'h08;
    localparam logic [7:0] REG_STATUS     = 8'h0C;
    localparam logic [7:0] REG_IRQ_STATUS = 8'h10;
    localparam logic [7:0] REG_IRQ_ENABLE = 8'h14;
    localparam logic [7:0] REG_RX_PKT_LO  = 8'h18;
    localparam logic [7:0] REG_RX_PKT_HI  = 8'h1C;
    localparam logic [7:0] REG_RX_DROP    = 8'h20;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_CLR_BIT  = 1;
    localparam int CTRL_MASK_LSB = 8;
    localparam int CTRL_MASK_MSB = 15;

    localparam logic [31:0] CSR_UNMAPPED_DATA = 32'hDEAD_BEEF;
    localparam logic [31:0] CSR_ID_DEFAULT    = 32'h4450_0001;

    typedef struct packed {
        logic [7:0] port_mask;
        logic       enable;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(ctrl_t c);
        logic [31:0] r;
        r = '0;
        r[CTRL_EN_BIT] = c.enable;
        r[CTRL_MASK_MSB:CTRL_MASK_LSB] = c.port_mask;
        return r;
    endfunction

endpackage

// File: rtl/dataplane_csr_counter.sv
// Clearable event counter, optionally saturating.
// Clear takes priority over increment.
module csr_counter
    import dataplane_csr_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(SATURATE && (&count))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dataplane_csr.sv
// Dataplane CSR bank: register-strobe decode with one-shot arming,
// control/irq registers, packet counters and read mux.
module dataplane_csr
    import dataplane_csr_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int          NUM_IRQ  = 8,
    parameter logic [31:0] ID_VALUE = CSR_ID_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        waddr,
    input  logic [31:0]        wdata,
    input  logic               we,
    output logic               wdone,
    input  logic [31:0]        raddr,
    input  logic               re,
    output logic               rdone,
    output logic [31:0]        rdata,
    input  logic               rx_pkt_i,
    input  logic               rx_drop_i,
    input  logic [NUM_IRQ-1:0] event_i,
    input  logic [31:0]        status_i,
    output logic               ctrl_enable,
    output logic [7:0]         ctrl_port_mask,
    output logic               irq
);

    logic               w_armed, r_armed;
    logic               w_acc, r_acc;
    logic [ADDR_W-1:0]  wa, ra;
    logic [31:0]        scratch;
    ctrl_t              ctrl;
    logic [NUM_IRQ-1:0] irq_status, irq_enable, w1c;
    logic [63:0]        pkt_cnt;
    logic [31:0]        pkt_hi_snap, drop_cnt, rmux;
    logic               wr_scratch, wr_ctrl, wr_istat, wr_ien;
    logic               rd_lo, cnt_clr;
    logic               unused_addr;

    assign unused_addr = ^{waddr, raddr};

    assign wa    = {waddr[ADDR_W-1:2], 2'b00};
    assign ra    = {raddr[ADDR_W-1:2], 2'b00};
    assign w_acc = we & w_armed;
    assign r_acc = re & r_armed;

    assign wr_scratch = w_acc && (wa == ADDR_W'(REG_SCRATCH));
    assign wr_ctrl    = w_acc && (wa == ADDR_W'(REG_CTRL));
    assign wr_istat   = w_acc && (wa == ADDR_W'(REG_IRQ_STATUS));
    assign wr_ien     = w_acc && (wa == ADDR_W'(REG_IRQ_ENABLE));
    assign rd_lo      = r_acc && (ra == ADDR_W'(REG_RX_PKT_LO));
    assign cnt_clr    = wr_ctrl & wdata[CTRL_CLR_BIT];
    assign w1c        = wr_istat ? wdata[NUM_IRQ-1:0] : '0;

    assign ctrl_enable    = ctrl.enable;
    assign ctrl_port_mask = ctrl.port_mask;

    csr_counter #(.WIDTH(64), .SATURATE(1'b0)) u_pkt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (rx_pkt_i),
        .count (pkt_cnt)
    );

    csr_counter #(.WIDTH(32), .SATURATE(1'b1)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (rx_drop_i),
        .count (drop_cnt)
    );

    // Mux reads pre-edge state, so a same-cycle write is not visible.
    always_comb begin
        rmux = CSR_UNMAPPED_DATA;
        unique case (ra)
            ADDR_W'(REG_ID):         rmux = ID_VALUE;
            ADDR_W'(REG_SCRATCH):    rmux = scratch;
            ADDR_W'(REG_CTRL):       rmux = ctrl_word(ctrl);
            ADDR_W'(REG_STATUS):     rmux = status_i;
            ADDR_W'(REG_IRQ_STATUS): rmux = 32'(irq_status);
            ADDR_W'(REG_IRQ_ENABLE): rmux = 32'(irq_enable);
            ADDR_W'(REG_RX_PKT_LO):  rmux = pkt_cnt[31:0];
            ADDR_W'(REG_RX_PKT_HI):  rmux = pkt_hi_snap;
            ADDR_W'(REG_RX_DROP):    rmux = drop_cnt;
            default:                 rmux = CSR_UNMAPPED_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_armed <= 1'b1;
            r_armed <= 1'b1;
            wdone   <= 1'b0;
            rdone   <= 1'b0;
            rdata   <= '0;
        end else begin
            wdone <= w_acc;
            rdone <= r_acc;
            if (w_acc)    w_armed <= 1'b0;
            else if (!we) w_armed <= 1'b1;
            if (r_acc)    r_armed <= 1'b0;
            else if (!re) r_armed <= 1'b1;
            if (r_acc)    rdata <= rmux;
        end
    end

    // Event set is OR-ed after the W1C mask so a coincident event wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch     <= '0;
            ctrl        <= '0;
            irq_status  <= '0;
            irq_enable  <= '0;
            irq         <= 1'b0;
            pkt_hi_snap <= '0;
        end else begin
            if (wr_scratch) scratch <= wdata;
            if (wr_ctrl) begin
                ctrl.enable    <= wdata[CTRL_EN_BIT];
                ctrl.port_mask <= wdata[CTRL_MASK_MSB:CTRL_MASK_LSB];
            end
            if (wr_ien) irq_enable <= wdata[NUM_IRQ-1:0];
            irq_status <= (irq_status & ~w1c) | event_i;
            irq        <= |(irq_status & irq_enable);
            if (cnt_clr)    pkt_hi_snap <= '0;
            else if (rd_lo) pkt_hi_snap <= pkt_cnt[63:32];
        end
    end

endmodule

// File: tb/tb_dataplane_csr.sv
// Directed bench for dataplane_csr: register table plus hand
// sequences for arming, irq, counters, collisions and reset.
module tb_dataplane_csr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] waddr, wdata, raddr, status_i;
    logic        we, re, wdone, rdone;
    logic [31:0] rdata;
    logic        rx_pkt_i, rx_drop_i;
    logic [7:0]  event_i;
    logic        ctrl_enable, irq;
    logic [7:0]  ctrl_port_mask;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dataplane_csr dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .waddr          (waddr),
        .wdata          (wdata),
        .we             (we),
        .wdone          (wdone),
        .raddr          (raddr),
        .re             (re),
        .rdone          (rdone),
        .rdata          (rdata),
        .rx_pkt_i       (rx_pkt_i),
        .rx_drop_i      (rx_drop_i),
        .event_i        (event_i),
        .status_i       (status_i),
        .ctrl_enable    (ctrl_enable),
        .ctrl_port_mask (ctrl_port_mask),
        .irq            (irq)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; side pulses set by caller last one cycle.
    task automatic do_write(string nm, logic [31:0] a, logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        rx_pkt_i = 1'b0; rx_drop_i = 1'b0; event_i = '0;
        chk({nm, ".wdone"}, 64'(wdone), 64'd1);
        we = 1'b0;
        @(negedge clk);
        chk({nm, ".wdone_end"}, 64'(wdone), 64'd0);
    endtask

    task automatic do_read(string nm, logic [31:0] a, logic [31:0] e);
        re = 1'b1; raddr = a;
        @(negedge clk);
        rx_pkt_i = 1'b0; rx_drop_i = 1'b0; event_i = '0;
        chk({nm, ".rdone"}, 64'(rdone), 64'd1);
        chk({nm, ".rdata"}, 64'(rdata), 64'(e));
        re = 1'b0;
        @(negedge clk);
        chk({nm, ".rdone_end"}, 64'(rdone), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; re = 1'b0;
        waddr = '0; wdata = '0; raddr = '0;
        rx_pkt_i = 1'b0; rx_drop_i = 1'b0; event_i = '0;
        status_i = 32'hCAFE_F00D;

        tbl[0]  = '{1'b0, 32'h00,  32'h0,         32'h4450_0001, "id"};
        tbl[1]  = '{1'b1, 32'h04,  32'h1234_5678, 32'h0,         "w_scr"};
        tbl[2]  = '{1'b0, 32'h04,  32'h0,         32'h1234_5678, "r_scr"};
        tbl[3]  = '{1'b1, 32'h08,  32'hFFFF_FFFF, 32'h0,         "w_ctrl_ff"};
        tbl[4]  = '{1'b0, 32'h08,  32'h0,         32'h0000_FF01, "r_ctrl_ff"};
        tbl[5]  = '{1'b1, 32'h08,  32'h0000_A501, 32'h0,         "w_ctrl"};
        tbl[6]  = '{1'b0, 32'h08,  32'h0,         32'h0000_A501, "r_ctrl"};
        tbl[7]  = '{1'b0, 32'h0C,  32'h0,         32'hCAFE_F00D, "r_status"};
        tbl[8]  = '{1'b0, 32'h3C,  32'h0,         32'hDEAD_BEEF, "r_unmap"};
        tbl[9]  = '{1'b1, 32'h3C,  32'hFFFF_FFFF, 32'h0,         "w_unmap"};
        tbl[10] = '{1'b0, 32'h04,  32'h0,         32'h1234_5678, "r_scr2"};
        tbl[11] = '{1'b0, 32'h104, 32'h0,         32'h1234_5678, "r_alias"};
        tbl[12] = '{1'b1, 32'h14,  32'h0000_01FF, 32'h0,         "w_ien_ff"};
        tbl[13] = '{1'b0, 32'h14,  32'h0,         32'h0000_00FF, "r_ien_ff"};
        tbl[14] = '{1'b1, 32'h14,  32'h0000_0004, 32'h0,         "w_ien"};
        tbl[15] = '{1'b0, 32'h14,  32'h0,         32'h0000_0004, "r_ien"};
        tbl[16] = '{1'b0, 32'h10,  32'h0,         32'h0,         "r_istat0"};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst.wdone", 64'(wdone), 64'd0);
        chk("rst.rdone", 64'(rdone), 64'd0);
        chk("rst.rdata", 64'(rdata), 64'd0);
        chk("rst.en",    64'(ctrl_enable), 64'd0);
        chk("rst.mask",  64'(ctrl_port_mask), 64'd0);
        chk("rst.irq",   64'(irq), 64'd0);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) do_write(tbl[i].nm, tbl[i].addr, tbl[i].data);
            else           do_read(tbl[i].nm, tbl[i].addr, tbl[i].exp);
        end
        chk("out.en",   64'(ctrl_enable), 64'd1);
        chk("out.mask", 64'(ctrl_port_mask), 64'hA5);

        // lingering we must not produce a second acknowledge
        we = 1'b1; waddr = 32'h04; wdata = 32'hAAAA_0000;
        @(negedge clk);
        chk("hold.wdone", 64'(wdone), 64'd1);
        @(negedge clk);
        chk("hold.extra1", 64'(wdone), 64'd0);
        @(negedge clk);
        chk("hold.extra2", 64'(wdone), 64'd0);
        we = 1'b0;
        @(negedge clk);
        do_read("hold.r", 32'h04, 32'hAAAA_0000);

        // interrupt latency and W1C vs event
        event_i = 8'h04;
        @(negedge clk);
        event_i = '0;
        chk("irq.early", 64'(irq), 64'd0);
        @(negedge clk);
        chk("irq.rise", 64'(irq), 64'd1);
        event_i = 8'h04;
        do_write("w1c_evt", 32'h10, 32'h4);
        do_read("w1c_evt.r", 32'h10, 32'h4);
        chk("irq.held", 64'(irq), 64'd1);
        do_write("w1c", 32'h10, 32'h4);
        chk("irq.fall", 64'(irq), 64'd0);
        do_read("w1c.r", 32'h10, 32'h0);
        event_i = 8'h20;
        @(negedge clk);
        event_i = '0;
        repeat (2) @(negedge clk);
        chk("irq.masked", 64'(irq), 64'd0);
        do_read("istat5", 32'h10, 32'h20);

        // 64-bit packet counter carry into the high word
        force dut.u_pkt_cnt.count = 64'h0000_0001_FFFF_FFFF;
        #1;
        release dut.u_pkt_cnt.count;
        rx_pkt_i = 1'b1;
        @(negedge clk);
        rx_pkt_i = 1'b0;
        rx_pkt_i = 1'b1;
        do_read("lo_coinc", 32'h18, 32'h0);
        do_read("hi", 32'h1C, 32'h2);
        do_read("lo_post", 32'h18, 32'h1);

        // drop counter saturation
        force dut.u_drop_cnt.count = 32'hFFFF_FFFE;
        #1;
        release dut.u_drop_cnt.count;
        rx_drop_i = 1'b1;
        repeat (3) @(negedge clk);
        rx_drop_i = 1'b0;
        do_read("drop_sat", 32'h20, 32'hFFFF_FFFF);

        // clear wins over coincident increments
        rx_drop_i = 1'b1;
        rx_pkt_i  = 1'b1;
        do_write("clr", 32'h08, 32'h0000_A503);
        do_read("clr.hi",   32'h1C, 32'h0);
        do_read("clr.drop", 32'h20, 32'h0);
        do_read("clr.lo",   32'h18, 32'h0);
        do_read("clr.ctrl", 32'h08, 32'h0000_A501);

        // same-cycle read and write of one register returns old data
        we = 1'b1; waddr = 32'h04; wdata = 32'hBBBB_0001;
        re = 1'b1; raddr = 32'h04;
        @(negedge clk);
        chk("coll.wdone", 64'(wdone), 64'd1);
        chk("coll.rdone", 64'(rdone), 64'd1);
        chk("coll.rdata", 64'(rdata), 64'hAAAA_0000);
        we = 1'b0; re = 1'b0;
        @(negedge clk);
        do_read("coll.r", 32'h04, 32'hBBBB_0001);

        // reset while an acknowledge is pending
        we = 1'b1; waddr = 32'h04; wdata = 32'h0000_0077;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid.wdone", 64'(wdone), 64'd0);
        chk("mid.rdata", 64'(rdata), 64'd0);
        chk("mid.en",    64'(ctrl_enable), 64'd0);
        chk("mid.mask",  64'(ctrl_port_mask), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid.rewrite", 64'(wdone), 64'd1);
        we = 1'b0;
        @(negedge clk);
        do_read("mid.scr",  32'h04, 32'h0000_0077);
        do_read("mid.ctrl", 32'h08, 32'h0);
        do_read("mid.ien",  32'h14, 32'h0);
        do_read("mid.istat", 32'h10, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
